// File: rtl/ha_serial_add_seq.sv
// -----------------------------------------------------------------------------
// ha_serial_add_seq
//   Sequencer that performs a WIDTH-bit add with carry-in by time-sharing one
//   external combinational half adder (sum = x ^ y, carry = x & y), LSB first.
//   Each bit takes two half-adder passes:
//     HA1: partial/c1 = a[i] + b[i]
//     HA2: s[i]/c2    = partial + running carry, new carry = c1 | c2
//   (c1 and c2 can never both be 1, so OR-ing them is the full-adder carry.)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand request handshake (in_ready high only in IDLE)
//   op_a, op_b, cin     operands, captured on accept
//   ha_x, ha_y          half-adder inputs (decoded from state, 0 when idle/done)
//   ha_sum, ha_carry    half-adder results
//   out_valid/out_ready result handshake; result held until out_ready
//   sum, cout           registered result
//   busy                high while the half adder is in use (HA1/HA2)
// -----------------------------------------------------------------------------
module ha_serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             ha_x,
  output logic             ha_y,
  input  logic             ha_sum,
  input  logic             ha_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HA1  = 2'd1,
    S_HA2  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             c1_q, c1_d;
  logic             p_q, p_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  // Next-state, datapath updates and half-adder input selection.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    c_d         = c_q;
    c1_d        = c1_q;
    p_d         = p_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ha_x        = 1'b0;
    ha_y        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          c_d     = cin;
          idx_d   = '0;
          state_d = S_HA1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HA1: begin
        ha_x    = a_q[idx_q];
        ha_y    = b_q[idx_q];
        p_d     = ha_sum;
        c1_d    = ha_carry;
        state_d = S_HA2;
      end
      S_HA2: begin
        ha_x       = p_q;
        ha_y       = c_q;
        s_d[idx_q] = ha_sum;
        c_d        = c1_q | ha_carry;
        if (idx_q == LAST_IDX) begin
          // Publish the result on the same edge the last bit lands.
          sum_d   = s_d;
          cout_d  = c1_q | ha_carry;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_HA1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake/status flags are registered, decoded from the next state.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_HA1) || (state_d == S_HA2);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      c_q         <= 1'b0;
      c1_q        <= 1'b0;
      p_q         <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      c_q         <= c_d;
      c1_q        <= c1_d;
      p_q         <= p_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_ha_serial_add_seq.sv
// -----------------------------------------------------------------------------
// tb_ha_serial_add_seq
//   Directed bench for ha_serial_add_seq (WIDTH=8) with a behavioural half
//   adder attached. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_ha_serial_add_seq;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             ha_x;
  logic             ha_y;
  logic             ha_sum;
  logic             ha_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int checks = 0;
  int fails  = 0;

  ha_serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .ha_x      (ha_x),
    .ha_y      (ha_y),
    .ha_sum    (ha_sum),
    .ha_carry  (ha_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // External half-adder cell.
  assign ha_sum   = ha_x ^ ha_y;
  assign ha_carry = ha_x & ha_y;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge; return at the falling edge after accept.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c);
    chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    op_a     = a;
    op_b     = b;
    cin      = c;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  // Wait (bounded) for out_valid; optionally scramble the request inputs meanwhile.
  task automatic wait_done(input bit scramble, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (scramble) begin
        in_valid = 1'($urandom_range(0, 1));
        op_a     = 8'($urandom);
        op_b     = 8'($urandom);
        cin      = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Consume the result and confirm return to IDLE.
  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_release", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after_release", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin : main
    int lat;
    logic [8:0] exp9;
    logic [7:0] ra, rb;
    logic       rc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = 8'h00;
    op_b      = 8'h00;
    cin       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'h00);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ha_x", {31'd0, ha_x}, 32'd0);

    // 5A + 3C -> 96, exact latency 16
    send(8'h5A, 8'h3C, 1'b0);
    wait_done(1'b0, lat);
    chk("lat_5a3c", lat, 32'd16);
    chk("sum_5a3c", {24'd0, sum}, 32'h96);
    chk("cout_5a3c", {31'd0, cout}, 32'd0);
    chk("ha_x_done", {31'd0, ha_x}, 32'd0);
    chk("busy_done", {31'd0, busy}, 32'd0);
    release_result();

    // Full ripple: FF + 01 -> 00, cout 1
    send(8'hFF, 8'h01, 1'b0);
    wait_done(1'b0, lat);
    chk("lat_ff01", lat, 32'd16);
    chk("res_ff01", {23'd0, cout, sum}, 32'h100);
    release_result();

    // FF + FF + 1 -> 1FF
    send(8'hFF, 8'hFF, 1'b1);
    wait_done(1'b0, lat);
    chk("res_ffff1", {23'd0, cout, sum}, 32'h1FF);
    release_result();

    // 00 + 00 + 1 -> 001
    send(8'h00, 8'h00, 1'b1);
    wait_done(1'b0, lat);
    chk("res_00001", {23'd0, cout, sum}, 32'h001);
    release_result();

    // Back-pressure: 12 + 34 -> 46, held 5 cycles while a new request is offered
    send(8'h12, 8'h34, 1'b0);
    wait_done(1'b0, lat);
    chk("res_1234", {23'd0, cout, sum}, 32'h046);
    op_a     = 8'h80;
    op_b     = 8'h80;
    cin      = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_res", {23'd0, cout, sum}, 32'h046);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_busy", {31'd0, busy}, 32'd0);
    end
    // Release with the new request still pending: IDLE next, then accepted.
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_out_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(1'b0, lat);
    chk("b2b_lat", lat, 32'd16);
    chk("b2b_res", {23'd0, cout, sum}, 32'h101);
    release_result();

    // Reset during cycle 7 of a run (previous result 0x101 gets cleared)
    send(8'hA5, 8'h5A, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_res", {23'd0, cout, sum}, 32'h000);
    send(8'h7F, 8'h01, 1'b1);
    wait_done(1'b0, lat);
    chk("post_rst_res", {23'd0, cout, sum}, 32'h081);
    release_result();

    // Scrambled inputs during the run must not disturb the captured operands
    send(8'hC3, 8'h4E, 1'b1);
    wait_done(1'b1, lat);
    chk("scramble_lat", lat, 32'd16);
    chk("scramble_res", {23'd0, cout, sum}, 32'h112);
    release_result();

    // Random sweep against a+b+cin
    for (int n = 0; n < 1000; n++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rc   = 1'($urandom_range(0, 1));
      exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      send(ra, rb, rc);
      wait_done(n[0], lat);
      chk("rand_res", {23'd0, cout, sum}, {23'd0, exp9});
      release_result();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
